mux_sel_sequencer: RTL and testbench
====================================

# mux_sel_sequencer

Generates the 5-bit select index for the 26:1 byte selector stage that sits directly downstream. It steps the index 0..25 from pre-debounced next/prev buttons, from an internal auto-advance prescaler, or from a direct load. It flags wrap-around and out-of-range loads. All outputs are registered, so the downstream mux sees a glitch-free select.

## Interface
- NUM_SEL, 26, number of valid select values; legal index range is 0..NUM_SEL-1.
- SEL_W, 5, select width; requires NUM_SEL <= 2**SEL_W.
- TICK_DIV, 100_000_000, clk cycles per auto-advance step (1 s at 100 MHz); must be >= 2.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_next  in  1  debounced level, synchronous to clk; a rising edge steps +1.
- btn_prev  in  1  debounced level, synchronous to clk; a rising edge steps -1.
- auto_en  in  1  level; high selects AUTO mode.
- hold  in  1  level; freezes stepping in any mode.
- sel_load  in  1  one-cycle strobe; loads sel_in.
- sel_in  in  SEL_W  load value.
- sel  out  SEL_W  select index to the downstream mux.
- wrap  out  1  one-cycle pulse when sel wraps (25->0 or 0->25).
- tick  out  1  one-cycle pulse when an auto-advance step is applied.
- load_err  out  1  one-cycle pulse when sel_in >= NUM_SEL on sel_load.
- mode  out  2  current state: 0 MANUAL, 1 AUTO, 2 PAUSE.

## Operation
- **Reset.**
  - sel=0, wrap=0, tick=0, load_err=0, mode=MANUAL, prescaler=0.
  - The button edge registers load the current btn_next/btn_prev levels, so a button held through reset produces no step.
- **Edge detect.** next_edge = btn_next & ~btn_next_q. Same for prev. The _q registers update every cycle.
- **FSM.**
  - MANUAL -> AUTO when auto_en=1 and hold=0.
  - AUTO -> MANUAL when auto_en=0.
  - MANUAL or AUTO -> PAUSE when hold=1.
  - PAUSE -> AUTO when hold=0 and auto_en=1.
  - PAUSE -> MANUAL when hold=0 and auto_en=0.
  - Transitions are evaluated every cycle from the current input levels.
- **Prescaler.**
  - Counts only in AUTO: 0..TICK_DIV-1. The terminal count raises an auto step and returns the counter to 0.
  - The counter is cleared on entry to AUTO, on any manual step or load while in AUTO, and in every other state.
- **Step priority** (per cycle, highest first):
  1. sel_load: load sel_in if < NUM_SEL, otherwise leave sel unchanged and pulse load_err.
  2. In PAUSE: nothing else applies.
  3. next_edge & prev_edge together: no change.
  4. next_edge: +1.
  5. prev_edge: -1.
  6. Auto step (AUTO only): +1 and pulse tick.
- sel_load is honoured in all states, including PAUSE. Button edges that occur during PAUSE are discarded, not queued.
- **Arithmetic.** +1 from NUM_SEL-1 gives 0. -1 from 0 gives NUM_SEL-1. Both cases pulse wrap. Loads never pulse wrap.
- Manual buttons work in AUTO as well as MANUAL. A manual step in AUTO restarts the prescaler, so the next auto step comes TICK_DIV cycles later.

## Timing
- **Event latency.** An event (edge, load, or terminal count) sampled at rising edge k updates sel, wrap, tick and load_err at edge k. They are visible in cycle k+1 and the pulses last exactly one cycle.
- **Auto cadence.** With AUTO entered at edge k, the first auto step occurs at edge k+TICK_DIV. Later steps follow every TICK_DIV cycles.
- **Mode.** mode is registered and reflects the transition one cycle after the inputs change.
- **Held buttons.** A button held high produces exactly one step. A new step requires a low cycle first.
- **Reset mid-operation.** Reset overrides every input in the same cycle, including sel_load. All outputs take their reset values at the next edge.
- There is no combinational path from inputs to outputs.

## Test plan
- **Reset and hold-through.** Set TICK_DIV=4. Hold btn_next=1 through reset. Release reset and keep btn_next high for 10 cycles -> sel stays 0, wrap=0, mode=0.
- **Manual wrap.**
  - From sel=0, a single btn_prev pulse -> sel=25 and wrap=1 for one cycle.
  - Then btn_next -> sel=0 with wrap=1.
  - btn_next and btn_prev rising in the same cycle -> sel unchanged, no pulses.
- **Auto run.** Raise auto_en at edge k with sel=24.
  - tick at k+4 gives sel=25, tick at k+8 gives sel=0 with wrap=1.
  - A btn_next at k+9 gives sel=1, and the next tick moves to k+13.
- **Pause.**
  - In AUTO, raise hold for 10 cycles and toggle btn_next during it -> sel frozen, no tick, mode=2.
  - Drop hold -> mode=1, and the first tick arrives 4 cycles later.
- **Load.**
  - sel_load with sel_in=13 -> sel=13, load_err=0.
  - sel_in=27 -> sel unchanged, load_err=1 for one cycle.
  - sel_load and btn_next in the same cycle -> sel=sel_in, with no +1 applied.
- **Reset mid-run.** Assert reset during AUTO with sel=7, together with sel_load (sel_in=3) -> at the next edge sel=0, mode=0, and all pulses are 0.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Generates the select index for the downstream 26:1 byte selector.
// The index steps +1/-1 on rising edges of the debounced next/prev buttons,
// +1 on each auto-advance prescaler terminal count (AUTO mode), or is loaded
// directly. Every output is a flop, so the downstream mux sees a clean select.
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      synchronous, active-high reset
//   btn_next_i   debounced level; rising edge steps +1
//   btn_prev_i   debounced level; rising edge steps -1
//   auto_en_i    level; selects AUTO mode
//   hold_i       level; freezes stepping (PAUSE)
//   sel_load_i   one-cycle strobe; loads sel_in_i
//   sel_in_i     load value
//   sel_o        select index 0..NUM_SEL-1
//   wrap_o       pulse when sel wraps (top->0 or 0->top)
//   tick_o       pulse when an auto step is applied
//   load_err_o   pulse when a load value is out of range
//   mode_o       0 MANUAL, 1 AUTO, 2 PAUSE
module mux_sel_sequencer #(
  parameter int NUM_SEL  = 26,
  parameter int SEL_W    = 5,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             btn_next_i,
  input  logic             btn_prev_i,
  input  logic             auto_en_i,
  input  logic             hold_i,
  input  logic             sel_load_i,
  input  logic [SEL_W-1:0] sel_in_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             wrap_o,
  output logic             tick_o,
  output logic             load_err_o,
  output logic [1:0]       mode_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(NUM_SEL - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    PAUSE  = 2'd2
  } mode_e;

  mode_e            state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             wrap_q, wrap_d;
  logic             tick_q, tick_d;
  logic             lerr_q, lerr_d;
  logic             btn_next_q, btn_prev_q;

  logic             next_edge, prev_edge, load_ok, term, restart;
  logic [SEL_W-1:0] sel_inc, sel_dec;

  assign next_edge = btn_next_i & ~btn_next_q;
  assign prev_edge = btn_prev_i & ~btn_prev_q;
  // One extra bit so NUM_SEL == 2**SEL_W still compares correctly.
  assign load_ok   = ({1'b0, sel_in_i} < (SEL_W+1)'(NUM_SEL));
  assign term      = (state_q == AUTO) && (cnt_q == CNT_W'(TICK_DIV - 1));
  assign sel_inc   = (sel_q == SEL_TOP) ? '0 : sel_q + SEL_W'(1);
  assign sel_dec   = (sel_q == '0) ? SEL_TOP : sel_q - SEL_W'(1);

  // Step priority: load, pause, button edges, auto step.
  // Any button activity or load restarts the auto cadence; a simultaneous
  // next+prev is a no-op step but still counts as manual activity.
  always_comb begin
    sel_d   = sel_q;
    wrap_d  = 1'b0;
    tick_d  = 1'b0;
    lerr_d  = 1'b0;
    restart = 1'b0;
    if (sel_load_i) begin
      restart = 1'b1;
      if (load_ok) sel_d  = sel_in_i;
      else         lerr_d = 1'b1;
    end else if (state_q != PAUSE) begin
      if (next_edge | prev_edge) begin
        restart = 1'b1;
        if (next_edge && !prev_edge) begin
          sel_d  = sel_inc;
          wrap_d = (sel_q == SEL_TOP);
        end else if (prev_edge && !next_edge) begin
          sel_d  = sel_dec;
          wrap_d = (sel_q == '0);
        end
      end else if (term) begin
        sel_d  = sel_inc;
        wrap_d = (sel_q == SEL_TOP);
        tick_d = 1'b1;
      end
    end
    // Counter only runs while already in AUTO, so entry always starts at 0.
    if (state_q != AUTO || restart || term) cnt_d = '0;
    else                                    cnt_d = cnt_q + CNT_W'(1);
  end

  // Edge registers track the buttons through reset too, so a button held
  // across reset release does not look like a fresh press.
  always_ff @(posedge clk_i) begin
    btn_next_q <= btn_next_i;
    btn_prev_q <= btn_prev_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= MANUAL;
      cnt_q   <= '0;
      sel_q   <= '0;
      wrap_q  <= 1'b0;
      tick_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
      tick_q <= tick_d;
      lerr_q <= lerr_d;
      case (state_q)
        MANUAL: begin
          if (hold_i)         state_q <= PAUSE;
          else if (auto_en_i) state_q <= AUTO;
        end
        AUTO: begin
          if (hold_i)          state_q <= PAUSE;
          else if (!auto_en_i) state_q <= MANUAL;
        end
        PAUSE: begin
          if (!hold_i) state_q <= auto_en_i ? AUTO : MANUAL;
        end
        default: state_q <= MANUAL;
      endcase
    end
  end

  assign sel_o      = sel_q;
  assign wrap_o     = wrap_q;
  assign tick_o     = tick_q;
  assign load_err_o = lerr_q;
  assign mode_o     = state_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
module tb_mux_sel_sequencer;
  localparam int NS = 26;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset, btn_next, btn_prev, auto_en, hold, sel_load;
  logic [4:0] sel_in;
  logic [4:0] sel;
  logic       wrap, tick, load_err;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;

  mux_sel_sequencer #(.NUM_SEL(NS), .SEL_W(5), .TICK_DIV(TD)) dut (
    .clk_i(clk), .reset_i(reset), .btn_next_i(btn_next), .btn_prev_i(btn_prev),
    .auto_en_i(auto_en), .hold_i(hold), .sel_load_i(sel_load), .sel_in_i(sel_in),
    .sel_o(sel), .wrap_o(wrap), .tick_o(tick), .load_err_o(load_err), .mode_o(mode)
  );

  always #5 clk = ~clk;

  // Reference model: index as an integer with modular arithmetic, auto
  // cadence as an absolute cycle number for the next due step.
  int m_sel, m_mode, m_wrap, m_tick, m_lerr;
  int cyc, next_due;
  logic pn, pp;

  task automatic model_edge();
    int  cur;
    logic ne, pe;
    if (reset) begin
      m_sel = 0; m_mode = 0; m_wrap = 0; m_tick = 0; m_lerr = 0;
      pn = btn_next; pp = btn_prev;
      return;
    end
    ne = btn_next && !pn;
    pe = btn_prev && !pp;
    pn = btn_next; pp = btn_prev;
    cur = m_mode;
    m_wrap = 0; m_tick = 0; m_lerr = 0;
    if (sel_load) begin
      if (sel_in < NS) m_sel = sel_in;
      else             m_lerr = 1;
      if (cur == 1) next_due = cyc + TD;
    end else if (cur != 2) begin
      if (ne || pe) begin
        if (ne && !pe) begin
          m_sel = (m_sel + 1) % NS;
          m_wrap = (m_sel == 0);
        end else if (pe && !ne) begin
          m_sel = (m_sel + NS - 1) % NS;
          m_wrap = (m_sel == NS - 1);
        end
        if (cur == 1) next_due = cyc + TD;
      end else if (cur == 1 && cyc == next_due) begin
        m_sel = (m_sel + 1) % NS;
        m_wrap = (m_sel == 0);
        m_tick = 1;
        next_due = cyc + TD;
      end
    end
    if (hold)         m_mode = 2;
    else if (auto_en) m_mode = 1;
    else              m_mode = 0;
    if (m_mode == 1 && cur != 1) next_due = cyc + TD;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("model.sel",      sel,      m_sel);
    chk("model.wrap",     wrap,     m_wrap);
    chk("model.tick",     tick,     m_tick);
    chk("model.load_err", load_err, m_lerr);
    chk("model.mode",     mode,     m_mode);
  endtask

  initial begin
    cyc = 0; next_due = 0; pn = 0; pp = 0;
    m_sel = 0; m_mode = 0; m_wrap = 0; m_tick = 0; m_lerr = 0;
    reset = 1; btn_next = 1; btn_prev = 0; auto_en = 0; hold = 0;
    sel_load = 0; sel_in = 0;
    #2;
    repeat (3) step();
    chk("reset.sel", sel, 0);
    chk("reset.mode", mode, 0);

    // Button held through reset release: no step.
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_thru.sel", sel, 0);
      chk("hold_thru.wrap", wrap, 0);
    end
    btn_next = 0; step();

    // Manual wrap both directions.
    btn_prev = 1; step();
    chk("prev_wrap.sel", sel, 25);
    chk("prev_wrap.wrap", wrap, 1);
    btn_prev = 0; step();
    chk("prev_wrap.pulse_end", wrap, 0);
    btn_next = 1; step();
    chk("next_wrap.sel", sel, 0);
    chk("next_wrap.wrap", wrap, 1);
    btn_next = 0; step();
    btn_next = 1; btn_prev = 1; step();
    chk("both.sel", sel, 0);
    chk("both.wrap", wrap, 0);
    btn_next = 0; btn_prev = 0; step();

    // Auto run from 24.
    sel_load = 1; sel_in = 24; step();
    sel_load = 0;
    chk("load24.sel", sel, 24);
    auto_en = 1; step();                       // edge k
    chk("auto.mode", mode, 1);
    repeat (3) begin step(); chk("auto.no_tick", tick, 0); end
    step();                                    // k+4
    chk("auto.tick1", tick, 1);
    chk("auto.sel25", sel, 25);
    repeat (3) step();
    step();                                    // k+8
    chk("auto.tick2", tick, 1);
    chk("auto.wrap_sel", sel, 0);
    chk("auto.wrap", wrap, 1);
    btn_next = 1; step();                      // k+9
    btn_next = 0;
    chk("auto.btn_sel", sel, 1);
    chk("auto.btn_no_tick", tick, 0);
    repeat (3) begin step(); chk("auto.restart_no_tick", tick, 0); end
    step();                                    // k+13
    chk("auto.tick3", tick, 1);
    chk("auto.tick3_sel", sel, 2);

    // Pause with button activity.
    hold = 1;
    for (int i = 0; i < 10; i++) begin
      btn_next = (i % 2 == 1);
      step();
      chk("pause.sel", sel, 2);
      chk("pause.tick", tick, 0);
      chk("pause.mode", mode, 2);
    end
    hold = 0; btn_next = 0; step();
    chk("unpause.mode", mode, 1);
    repeat (3) begin step(); chk("unpause.no_tick", tick, 0); end
    step();
    chk("unpause.tick", tick, 1);
    chk("unpause.sel", sel, 3);

    // Loads.
    sel_load = 1; sel_in = 13; step();
    chk("load13.sel", sel, 13);
    chk("load13.err", load_err, 0);
    sel_in = 27; step();
    chk("load27.sel", sel, 13);
    chk("load27.err", load_err, 1);
    sel_load = 0; step();
    chk("load27.err_end", load_err, 0);
    sel_load = 1; sel_in = 5; btn_next = 1; step();
    chk("load_vs_btn.sel", sel, 5);
    sel_load = 0; btn_next = 0;

    // Reset mid-run overrides a load.
    sel_load = 1; sel_in = 7; step();
    chk("pre_reset.sel", sel, 7);
    reset = 1; sel_in = 3; step();
    chk("mid_reset.sel", sel, 0);
    chk("mid_reset.mode", mode, 0);
    chk("mid_reset.pulses", {wrap, tick, load_err}, 0);
    reset = 0; sel_load = 0; auto_en = 0; step();

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      sel_load = ($urandom_range(0, 19) == 0);
      sel_in   = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 3) == 0) btn_prev = ~btn_prev;
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 39) == 0) hold = ~hold;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
